mem_im_dm_dram: RTL and testbench

// - Memory-side model for the RISC-V SoC bench: instruction SRAM (IM), data SRAM (DM) and a RAS/CAS DRAM.
// - Sits outside top/CPU and serves the CPU memory ports.
// - Arrays are preloadable by hierarchical $readmemh; nothing is initialised by reset.
// - DM word 65535 == 32'hFFFF_F000 is the program finish flag; the block does not interpret it.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_im_dm_dram_if.sv | 41 ++++
 rtl/sram_1rw.sv | 38 +++
 rtl/mem_im_dm_dram.sv | 135 +++++++++++++
 tb/tb_mem_im_dm_dram.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared widths and DRAM state type for the SoC memory-side model.
package mem_pkg;

    localparam int unsigned SRAM_AW    = 16;
    localparam int unsigned DRAM_ROW_W = 11;
    localparam int unsigned DRAM_COL_W = 10;
    localparam int unsigned DRAM_CL    = 1;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } dram_state_e;

endpackage

// File: rtl/mem_im_dm_dram_if.sv
// CPU-facing memory bus: IM and DM SRAM ports plus the RAS/CAS DRAM port.
interface mem_im_dm_dram_if;
    import mem_pkg::*;

    logic                  im_enable;
    logic                  im_write;
    logic [SRAM_AW-1:0]    im_addr;
    logic [DATA_W-1:0]     im_in;
    logic [DATA_W-1:0]     im_out;

    logic                  dm_enable;
    logic                  dm_write;
    logic [SRAM_AW-1:0]    dm_addr;
    logic [DATA_W-1:0]     dm_in;
    logic [DATA_W-1:0]     dm_out;

    logic                  dram_csn;
    logic                  dram_rasn;
    logic                  dram_casn;
    logic                  dram_wen;
    logic [DRAM_ROW_W-1:0] dram_a;
    logic [DATA_W-1:0]     dram_d;
    logic [DATA_W-1:0]     dram_q;

    // CPU side
    modport master (
        output im_enable, im_write, im_addr, im_in,
        output dm_enable, dm_write, dm_addr, dm_in,
        output dram_csn, dram_rasn, dram_casn, dram_wen, dram_a, dram_d,
        input  im_out, dm_out, dram_q
    );

    // Memory side
    modport slave (
        input  im_enable, im_write, im_addr, im_in,
        input  dm_enable, dm_write, dm_addr, dm_in,
        input  dram_csn, dram_rasn, dram_casn, dram_wen, dram_a, dram_d,
        output im_out, dm_out, dram_q
    );

endinterface

// File: rtl/sram_1rw.sv
// Synchronous single-port SRAM, one access per cycle, registered read data.
module sram_1rw
    import mem_pkg::*;
#(
    parameter int unsigned AW = SRAM_AW,
    parameter int unsigned DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] in,
    output logic [DW-1:0] out
);

    localparam int unsigned DEPTH = 32'd1 << AW;

    // Contents are preloaded hierarchically and never touched by reset.
    logic [DW-1:0] mem_data [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (enable && write) begin
            mem_data[addr] <= in;
        end
    end

    // Read data register; holds on write or idle cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (enable && !write) begin
            out <= mem_data[addr];
        end
    end

endmodule

// File: rtl/mem_im_dm_dram.sv
// Memory-side model: instruction SRAM, data SRAM and a RAS/CAS DRAM.
module mem_im_dm_dram
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mem_im_dm_dram_if.slave   bus
);

    sram_1rw #(.AW(SRAM_AW), .DW(DATA_W)) u_im (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.im_enable),
        .write  (bus.im_write),
        .addr   (bus.im_addr),
        .in     (bus.im_in),
        .out    (bus.im_out)
    );

    sram_1rw #(.AW(SRAM_AW), .DW(DATA_W)) u_dm (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.dm_enable),
        .write  (bus.dm_write),
        .addr   (bus.dm_addr),
        .in     (bus.dm_in),
        .out    (bus.dm_out)
    );

    if (1'b1) begin : u_dram
        localparam int unsigned WA_W  = DRAM_ROW_W + DRAM_COL_W;
        localparam int unsigned DEPTH = 32'd1 << WA_W;

        logic [DATA_W-1:0]     mem_data [DEPTH];
        dram_state_e           state_q;
        dram_state_e           state_d;
        logic [DRAM_ROW_W-1:0] row_q;
        logic [DRAM_ROW_W-1:0] row_d;
        logic                  cas_wr_c;
        logic                  cas_rd_c;
        logic [WA_W-1:0]       word_addr_c;
        logic [DATA_W-1:0]     rd_data_c;
        logic [DATA_W-1:0]     q_q;

        // Bank state and open row
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                row_q   <= '0;
            end else begin
                state_q <= state_d;
                row_q   <= row_d;
            end
        end

        // Command decode: activate/precharge and CAS qualification
        always_comb begin
            state_d     = state_q;
            row_d       = row_q;
            cas_wr_c    = 1'b0;
            cas_rd_c    = 1'b0;
            word_addr_c = {row_q, bus.dram_a[DRAM_COL_W-1:0]};
            if (!bus.dram_csn) begin
                case (state_q)
                    IDLE: begin
                        if (!bus.dram_rasn) begin
                            state_d = ACTIVE;
                            row_d   = bus.dram_a;
                        end
                    end
                    ACTIVE: begin
                        if (bus.dram_rasn) begin
                            state_d = IDLE;
                        end else if (!bus.dram_casn) begin
                            cas_wr_c = !bus.dram_wen;
                            cas_rd_c = bus.dram_wen;
                        end
                    end
                endcase
            end
        end

        // Array word sampled at the CAS edge, so later writes cannot disturb it
        always_comb begin
            rd_data_c = mem_data[word_addr_c];
        end

        // Array write port
        always_ff @(posedge clk) begin
            if (cas_wr_c) begin
                mem_data[word_addr_c] <= bus.dram_d;
            end
        end

        if (DRAM_CL == 32'd1) begin : g_cl1
            // Read data lands at the CAS edge itself
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    q_q <= '0;
                end else if (cas_rd_c) begin
                    q_q <= rd_data_c;
                end
            end
        end else begin : g_cln
            localparam int unsigned PD = DRAM_CL - 32'd1;

            logic [PD-1:0]     vld_q;
            logic [DATA_W-1:0] data_q [PD];

            // CAS latency pipeline; dram_q updates only when a read retires
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < int'(PD); i++) begin
                        data_q[i] <= '0;
                    end
                    q_q <= '0;
                end else begin
                    vld_q[0]  <= cas_rd_c;
                    data_q[0] <= rd_data_c;
                    for (int i = 1; i < int'(PD); i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                    if (vld_q[PD-1]) begin
                        q_q <= data_q[PD-1];
                    end
                end
            end
        end

        assign bus.dram_q = q_q;
    end

endmodule

// File: tb/tb_mem_im_dm_dram.sv
// Directed and randomized bench for the IM/DM/DRAM memory model.
module tb_mem_im_dm_dram;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_im_dm_dram_if bus();

    mem_im_dm_dram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sparse memories, open-row flag, queue of reads in flight
    typedef struct {
        int          due;
        bit          known;
        logic [31:0] d;
    } rd_t;

    logic [31:0] im_m   [int];
    logic [31:0] dm_m   [int];
    logic [31:0] dram_m [int];
    rd_t         pend   [$];
    logic [31:0] exp_im, exp_dm, exp_q;
    bit          kn_im, kn_dm, kn_q;
    bit          row_open;
    int          open_row;
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_im = '0; exp_dm = '0; exp_q = '0;
        kn_im = 1'b1; kn_dm = 1'b1; kn_q = 1'b1;
        row_open = 1'b0;
        pend.delete();
    endtask

    task automatic model_step();
        int  a;
        rd_t r;
        if (!rst) return;
        cyc++;
        if (bus.im_enable) begin
            a = int'(bus.im_addr);
            if (bus.im_write) im_m[a] = bus.im_in;
            else begin
                kn_im  = im_m.exists(a);
                exp_im = kn_im ? im_m[a] : 32'h0;
            end
        end
        if (bus.dm_enable) begin
            a = int'(bus.dm_addr);
            if (bus.dm_write) dm_m[a] = bus.dm_in;
            else begin
                kn_dm  = dm_m.exists(a);
                exp_dm = kn_dm ? dm_m[a] : 32'h0;
            end
        end
        if (!bus.dram_csn) begin
            if (!row_open) begin
                if (!bus.dram_rasn) begin
                    row_open = 1'b1;
                    open_row = int'(bus.dram_a);
                end
            end else if (bus.dram_rasn) begin
                row_open = 1'b0;
            end else if (!bus.dram_casn) begin
                a = open_row * (1 << DRAM_COL_W) + (int'(bus.dram_a) % (1 << DRAM_COL_W));
                if (!bus.dram_wen) dram_m[a] = bus.dram_d;
                else begin
                    r.due   = cyc + int'(DRAM_CL) - 1;
                    r.known = dram_m.exists(a);
                    r.d     = r.known ? dram_m[a] : 32'h0;
                    pend.push_back(r);
                end
            end
        end
        while (pend.size() > 0 && pend[0].due == cyc) begin
            kn_q  = pend[0].known;
            exp_q = pend[0].d;
            pend.delete(0);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (kn_im) check("im_out", bus.im_out, exp_im);
        if (kn_dm) check("dm_out", bus.dm_out, exp_dm);
        if (kn_q)  check("dram_q", bus.dram_q, exp_q);
    endtask

    task automatic idle();
        bus.im_enable = 1'b0; bus.im_write = 1'b0; bus.im_addr = '0; bus.im_in = '0;
        bus.dm_enable = 1'b0; bus.dm_write = 1'b0; bus.dm_addr = '0; bus.dm_in = '0;
        bus.dram_csn = 1'b1; bus.dram_rasn = 1'b1; bus.dram_casn = 1'b1;
        bus.dram_wen = 1'b1; bus.dram_a = '0; bus.dram_d = '0;
    endtask

    task automatic im_op(input bit wr, input logic [15:0] a, input logic [31:0] d);
        bus.im_enable = 1'b1; bus.im_write = wr; bus.im_addr = a; bus.im_in = d;
        tick();
        bus.im_enable = 1'b0;
    endtask

    task automatic dm_op(input bit en, input bit wr, input logic [15:0] a, input logic [31:0] d);
        bus.dm_enable = en; bus.dm_write = wr; bus.dm_addr = a; bus.dm_in = d;
        tick();
        bus.dm_enable = 1'b0;
    endtask

    task automatic dram(input bit csn, input bit rasn, input bit casn, input bit wen,
                        input logic [10:0] a, input logic [31:0] d);
        bus.dram_csn = csn; bus.dram_rasn = rasn; bus.dram_casn = casn;
        bus.dram_wen = wen; bus.dram_a = a; bus.dram_d = d;
        tick();
        bus.dram_csn = 1'b1; bus.dram_rasn = 1'b1; bus.dram_casn = 1'b1; bus.dram_wen = 1'b1;
    endtask

    task automatic wait_cl();
        for (int i = 1; i < int'(DRAM_CL); i++) tick();
    endtask

    initial begin
        idle();
        // Power-on reset
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst_im", bus.im_out, 32'h0);
        check("rst_dm", bus.dm_out, 32'h0);
        check("rst_q",  bus.dram_q, 32'h0);
        repeat (2) tick();
        #2 rst = 1'b1;

        // Content written before a reset survives it
        dm_op(1'b1, 1'b1, 16'd5, 32'h0000_1234);
        dm_op(1'b1, 1'b0, 16'd5, 32'h0);
        check("dm_pre", bus.dm_out, 32'h0000_1234);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst2_dm", bus.dm_out, 32'h0);
        tick();
        #2 rst = 1'b1;
        dm_op(1'b1, 1'b0, 16'd5, 32'h0);
        check("dm_preload_kept", bus.dm_out, 32'h0000_1234);

        // DM write then read, then hold with enable low
        dm_op(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        check("dm_wr_holds_out", bus.dm_out, 32'h0000_1234);
        dm_op(1'b1, 1'b0, 16'h0010, 32'h0);
        check("dm_rd", bus.dm_out, 32'hDEAD_BEEF);
        dm_op(1'b0, 1'b0, 16'd5, 32'h0);
        check("dm_hold", bus.dm_out, 32'hDEAD_BEEF);

        // Top-of-array addresses
        im_op(1'b1, 16'hFFFF, 32'h0000_0013);
        im_op(1'b0, 16'hFFFF, 32'h0);
        check("im_top", bus.im_out, 32'h0000_0013);
        dm_op(1'b1, 1'b1, 16'hFFFF, 32'hFFFF_F000);
        dm_op(1'b1, 1'b0, 16'hFFFF, 32'h0);
        check("dm_top", bus.dm_out, 32'hFFFF_F000);

        // DRAM write, precharge, re-activate, read
        dram(1'b0, 1'b0, 1'b1, 1'b1, 11'h001, 32'h0);
        dram(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 32'hCAFE_0001);
        dram(1'b0, 1'b1, 1'b1, 1'b1, 11'h000, 32'h0);
        dram(1'b0, 1'b0, 1'b1, 1'b1, 11'h001, 32'h0);
        dram(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 32'h0);
        wait_cl();
        check("dram_rw", bus.dram_q, 32'hCAFE_0001);
        dram(1'b0, 1'b1, 1'b1, 1'b1, 11'h000, 32'h0);

        // Illegal/ignored CAS cases must not write
        dram(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 32'hBAD0_0001);
        dram(1'b0, 1'b0, 1'b1, 1'b1, 11'h001, 32'h0);
        dram(1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 32'hBAD0_0002);
        dram(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 32'hBAD0_0004);
        check("dram_q_unchanged", bus.dram_q, 32'hCAFE_0001);
        dram(1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 32'hBAD0_0003);
        dram(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 32'h0);
        wait_cl();
        check("dram_protocol", bus.dram_q, 32'hCAFE_0001);
        dram(1'b0, 1'b1, 1'b1, 1'b1, 11'h000, 32'h0);

        // Burst: fill row 2, then four back-to-back reads
        dram(1'b0, 1'b0, 1'b1, 1'b1, 11'h002, 32'h0);
        for (int i = 0; i < 4; i++)
            dram(1'b0, 1'b0, 1'b0, 1'b0, 11'(i), 32'hB000_0000 + 32'(i));
        dram(1'b0, 1'b1, 1'b1, 1'b1, 11'h000, 32'h0);
        dram(1'b0, 1'b0, 1'b1, 1'b1, 11'h002, 32'h0);
        for (int i = 0; i < 4 + int'(DRAM_CL) - 1; i++) begin
            if (i < 4) dram(1'b0, 1'b0, 1'b0, 1'b1, 11'(i), 32'h0);
            else       dram(1'b1, 1'b1, 1'b1, 1'b1, 11'h000, 32'h0);
            if (i >= int'(DRAM_CL) - 1)
                check("burst", bus.dram_q, 32'hB000_0000 + 32'(i - (int'(DRAM_CL) - 1)));
        end

        // Reset in the middle of a burst
        dram(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 32'h0);
        dram(1'b0, 1'b0, 1'b0, 1'b1, 11'h001, 32'h0);
        #1 rst = 1'b0;
        model_reset();
        #1;
        check("burst_rst_q", bus.dram_q, 32'h0);
        #1 rst = 1'b1;
        dram(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 32'hDEAD_0000);
        dram(1'b0, 1'b1, 1'b1, 1'b1, 11'h000, 32'h0);
        dram(1'b0, 1'b0, 1'b1, 1'b1, 11'h002, 32'h0);
        dram(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 32'h0);
        wait_cl();
        check("row_closed", bus.dram_q, 32'hB000_0000);

        // Randomized traffic on all three ports against the model
        for (int n = 0; n < 400; n++) begin
            bus.im_enable = 1'($urandom_range(0, 1));
            bus.im_write  = 1'($urandom_range(0, 1));
            bus.im_addr   = 16'($urandom_range(0, 7));
            bus.im_in     = $urandom;
            bus.dm_enable = 1'($urandom_range(0, 1));
            bus.dm_write  = 1'($urandom_range(0, 1));
            bus.dm_addr   = 16'hFFF8 + 16'($urandom_range(0, 7));
            bus.dm_in     = $urandom;
            bus.dram_csn  = ($urandom_range(0, 9) == 0);
            bus.dram_rasn = ($urandom_range(0, 5) == 0);
            bus.dram_casn = 1'($urandom_range(0, 1));
            bus.dram_wen  = 1'($urandom_range(0, 1));
            bus.dram_a    = 11'($urandom_range(0, 3));
            bus.dram_d    = $urandom;
            tick();
        end
        idle();
        repeat (int'(DRAM_CL) + 1) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
